spi_fpu_bridge: RTL and testbench

//  Parametrised SPI-slave command bridge that sits between the chip pins and an arithmetic

---
 rtl/spi_fpu_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_spi_fpu_bridge.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fpu_bridge.sv
// spi_fpu_bridge: SPI mode-0 slave that frames commands for an arithmetic core and reads back results
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   sclk, cs_n, mosi, miso   SPI slave pins (inputs asynchronous, oversampled in clk domain)
//   op_valid/op_ready        command handshake to the core, with op_code, op_a, op_b
//   res_valid                one-cycle result strobe from the core, with res_data, res_flags
module spi_fpu_bridge #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int SYNC_N  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [6:0]        op_code,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic [3:0]        res_flags
);
    localparam int FRAME_W = 8 + 2 * DATA_W;
    localparam int TX_W    = 8 + DATA_W;
    localparam int CW      = $clog2(FRAME_W + 2);
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [SYNC_N-1:0]  sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic               sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic               active_q, active_d, rd_q, rd_d, miso_q, miso_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0] rx_q, rx_d;
    logic [7:0]         opc_q, opc_d;
    logic [TX_W-1:0]    tx_q, tx_d;
    state_t             state_q, state_d;
    logic               op_valid_q, op_valid_d;
    logic [6:0]         op_code_q, op_code_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d, tmo_q, tmo_d, rej_q, rej_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic               accept, reject;
    logic [7:0]         opc_now, status;

    assign sclk_s    = sclk_sync_q[SYNC_N-1];
    assign cs_s      = cs_sync_q[SYNC_N-1];
    assign mosi_s    = mosi_sync_q[SYNC_N-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    // a frame only ends if one was seen to start, so reset mid-frame leaves the tail ignored
    assign cs_rise   = cs_s & ~cs_prev_q & active_q;
    assign opc_now   = {rx_q[6:0], mosi_s};
    assign accept    = cs_rise && bit_cnt_q == CW'(FRAME_W) && !opc_q[7] && state_q == IDLE;
    // anything with a full opcode byte that is not a READ and not accepted is refused
    assign reject    = cs_rise && bit_cnt_q >= CW'(8) && opc_q != 8'h80 && !accept;
    assign status    = {state_q != IDLE, done_q, tmo_q, rej_q, flags_q};

    assign miso     = miso_q;
    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_N-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_N-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_N-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        active_d    = active_q;
        rd_d        = rd_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        opc_d       = opc_q;
        tx_d        = tx_q;
        miso_d      = cs_s ? 1'b0 : miso_q;
        if (cs_fall) begin
            active_d  = 1'b1;
            rd_d      = 1'b0;
            bit_cnt_d = '0;
            opc_d     = '0;
        end else if (cs_rise) begin
            active_d = 1'b0;
            rd_d     = 1'b0;
        end else if (active_q && sclk_rise) begin
            rx_d      = {rx_q[FRAME_W-3:0], mosi_s};
            // saturate one past a full frame so overlong frames stay distinguishable
            bit_cnt_d = bit_cnt_q == CW'(FRAME_W + 1) ? bit_cnt_q : bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(7)) begin
                opc_d = opc_now;
                if (opc_now == 8'h80) begin
                    rd_d = 1'b1;
                    tx_d = {status, result_q};
                end
            end
        end else if (rd_q && sclk_fall) begin
            miso_d = tx_q[TX_W-1];
            tx_d   = {tx_q[TX_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        op_valid_d = op_valid_q;
        op_code_d  = op_code_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        flags_d    = flags_q;
        done_d     = done_q;
        tmo_d      = tmo_q;
        rej_d      = rej_q;
        tmo_cnt_d  = tmo_cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = ISSUE;
                op_valid_d = 1'b1;
                op_code_d  = rx_q[FRAME_W-2 -: 7];
                op_a_d     = rx_q[2*DATA_W-1 -: DATA_W];
                op_b_d     = rx_q[DATA_W-1:0];
            end
            ISSUE: if (op_ready) begin
                state_d    = WAIT;
                op_valid_d = 1'b0;
                done_d     = 1'b0;
                tmo_d      = 1'b0;
                rej_d      = 1'b0;
                tmo_cnt_d  = '0;
            end
            WAIT: if (res_valid) begin
                state_d  = IDLE;
                result_d = res_data;
                flags_d  = res_flags;
                done_d   = 1'b1;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (reject) rej_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            active_q    <= 1'b0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            opc_q       <= '0;
            tx_q        <= '0;
            state_q     <= IDLE;
            op_valid_q  <= 1'b0;
            op_code_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            rej_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            active_q    <= active_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            opc_q       <= opc_d;
            tx_q        <= tx_d;
            state_q     <= state_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            rej_q       <= rej_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end
endmodule

// File: tb/tb_spi_fpu_bridge.sv
// tb_spi_fpu_bridge: randomized self-checking bench for spi_fpu_bridge against a status/result model
module tb_spi_fpu_bridge;
    localparam int DW  = 32;
    localparam int TMO = 1500;
    localparam int FW  = 8 + 2 * DW;
    localparam int TXW = 8 + DW;

    logic          clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0, op_ready = 0, res_valid = 0;
    logic [DW-1:0] res_data = '0;
    logic [3:0]    res_flags = '0;
    logic          miso, op_valid;
    logic [6:0]    op_code;
    logic [DW-1:0] op_a, op_b;
    int            errors = 0, checks = 0;

    spi_fpu_bridge #(.DATA_W(DW), .TIMEOUT(TMO), .SYNC_N(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic          m_done = 0, m_tmo = 0, m_rej = 0;
    logic [3:0]    m_flags = '0;
    logic [DW-1:0] m_result = '0;

    function automatic logic [7:0] exp_status(input logic busy);
        return {busy, m_done, m_tmo, m_rej, m_flags};
    endfunction

    task automatic m_clear();
        m_done = 0; m_tmo = 0; m_rej = 0; m_flags = '0; m_result = '0;
    endtask

    task automatic m_accept();
        m_done = 0; m_tmo = 0; m_rej = 0;
    endtask

    int            pulses = 0, hi_len = 0;
    logic          ov_prev = 0, unstable = 0;
    logic [6:0]    cap_code = '0;
    logic [DW-1:0] cap_a = '0, cap_b = '0;

    always @(negedge clk) begin
        if (op_valid) begin
            if (!ov_prev) begin
                pulses++; hi_len = 1; unstable = 0;
                cap_code = op_code; cap_a = op_a; cap_b = op_b;
            end else begin
                hi_len++;
                if ({op_code, op_a, op_b} !== {cap_code, cap_a, cap_b}) unstable = 1;
            end
        end
        ov_prev = op_valid;
    end

    logic [TXW-1:0] rd_bits;
    logic           opc_miso, miso_after_rst;

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; sclk = 0; cs_n = 1; mosi = 0; op_ready = 0; res_valid = 0;
        clk_n(3);
        rst = 0;
        m_clear();
        clk_n(5);
    endtask

    task automatic pulse_res(input logic [DW-1:0] d, input logic [3:0] f);
        res_data = d; res_flags = f; res_valid = 1;
        clk_n(1);
        res_valid = 0;
    endtask

    task automatic spi_xfer(input logic [255:0] v, input int n, input int rst_at);
        rd_bits = '0; opc_miso = 0;
        cs_n = 1; clk_n(10);
        cs_n = 0; clk_n(5);
        for (int i = 0; i < n; i++) begin
            mosi = v[n-1-i];
            clk_n(5);
            sclk = 1;
            if (i < 8) opc_miso = opc_miso | miso;
            else if (i - 8 < TXW) rd_bits[TXW-1-(i-8)] = miso;
            if (i == rst_at) begin
                rst = 1; clk_n(1); rst = 0; clk_n(1);
                miso_after_rst = miso;
            end
            clk_n(5);
            sclk = 0;
        end
        clk_n(5);
        cs_n = 1; mosi = 0;
        clk_n(1);
    endtask

    task automatic spi_write(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
        logic [255:0] v;
        v = '0;
        v[FW-1:0] = {op, a, b};
        if (n >= FW) spi_xfer(v << (n - FW), n, -1);
        else spi_xfer(v >> (FW - n), n, -1);
    endtask

    task automatic spi_read(output logic [7:0] st, output logic [DW-1:0] r, input int rst_at);
        logic [255:0] v;
        v = '0;
        v[8+TXW-1 -: 8] = 8'h80;
        spi_xfer(v, 8 + TXW, rst_at);
        st = rd_bits[TXW-1 -: 8];
        r  = rd_bits[DW-1:0];
    endtask

    task automatic wait_pulse(input int p0, output logic ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (pulses > p0) begin ok = 1; break; end
            clk_n(1);
        end
    endtask

    task automatic test_reset();
        logic [7:0] st; logic [DW-1:0] r;
        do_reset();
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
        checks++; if (op_code !== 7'h0) begin errors++; $display("FAIL reset_op_code: got %h expected 00", op_code); end
        checks++; if (op_a !== '0) begin errors++; $display("FAIL reset_op_a: got %h expected 0", op_a); end
        checks++; if (op_b !== '0) begin errors++; $display("FAIL reset_op_b: got %h expected 0", op_b); end
        spi_read(st, r, -1);
        checks++; if (st !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", st); end
        checks++; if (r !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", r); end
    endtask

    task automatic test_write_read();
        logic [7:0] op, st; logic [DW-1:0] a, b, res, r; logic [3:0] f; logic ok; int p0;
        do_reset();
        op_ready = 1;
        for (int it = 0; it < 4; it++) begin
            op  = (it == 0) ? 8'h01 : 8'($urandom_range(0, 127));
            a   = (it == 0) ? 32'h3F800000 : $urandom;
            b   = (it == 0) ? 32'h40000000 : $urandom;
            res = (it == 0) ? 32'h40400000 : $urandom;
            f   = (it == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            p0 = pulses;
            spi_write(op, a, b, FW);
            wait_pulse(p0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL wr_op_valid it%0d: got none expected a pulse", it); end
            m_accept();
            clk_n(12);
            checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL wr_pulse_count it%0d: got %0d expected %0d", it, pulses - p0, 1); end
            checks++; if (hi_len !== 1) begin errors++; $display("FAIL wr_pulse_len it%0d: got %0d expected 1", it, hi_len); end
            checks++; if ({cap_code, cap_a, cap_b} !== {op[6:0], a, b}) begin errors++; $display("FAIL wr_operands it%0d: got %h/%h/%h expected %h/%h/%h", it, cap_code, cap_a, cap_b, op[6:0], a, b); end
            pulse_res(res, f);
            m_result = res; m_flags = f; m_done = 1;
            spi_read(st, r, -1);
            checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL rd_status it%0d: got %h expected %h", it, st, exp_status(0)); end
            checks++; if (r !== m_result) begin errors++; $display("FAIL rd_result it%0d: got %h expected %h", it, r, m_result); end
            checks++; if (opc_miso !== 1'b0) begin errors++; $display("FAIL rd_opcode_phase_miso it%0d: got %b expected 0", it, opc_miso); end
            checks++; if (miso !== 1'b0) begin errors++; $display("FAIL idle_miso it%0d: got %b expected 0", it, miso); end
        end
    endtask

    task automatic test_bad_frames();
        logic [7:0] st; logic [DW-1:0] r; int p0;
        do_reset();
        op_ready = 1;
        p0 = pulses;
        spi_write(8'h01, $urandom, $urandom, FW - 1);
        clk_n(20);
        checks++; if (pulses !== p0) begin errors++; $display("FAIL short_no_issue: got %0d pulses expected 0", pulses - p0); end
        m_rej = 1;
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL short_status: got %h expected %h", st, exp_status(0)); end
        spi_write(8'h05, $urandom, $urandom, FW + 1);
        spi_write(8'($urandom_range(129, 255)), $urandom, $urandom, FW);
        clk_n(20);
        checks++; if (pulses !== p0) begin errors++; $display("FAIL long_reserved_no_issue: got %0d pulses expected 0", pulses - p0); end
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL long_reserved_status: got %h expected %h", st, exp_status(0)); end
    endtask

    task automatic test_hold();
        logic [7:0] op, st; logic [DW-1:0] a, b, res, r; logic [3:0] f; logic ok;
        do_reset();
        op = 8'($urandom_range(0, 127)); a = $urandom; b = $urandom;
        res = $urandom; f = 4'($urandom_range(0, 15));
        spi_write(op, a, b, FW);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (op_valid) begin ok = 1; break; end
            clk_n(1);
        end
        checks++; if (!ok) begin errors++; $display("FAIL hold_op_valid: got none expected op_valid"); end
        clk_n(5);
        op_ready = 1;
        m_accept();
        clk_n(3);
        checks++; if (hi_len !== 6) begin errors++; $display("FAIL hold_len: got %0d expected 6", hi_len); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL hold_stable: got changing op_* expected stable"); end
        checks++; if ({cap_code, cap_a, cap_b} !== {op[6:0], a, b}) begin errors++; $display("FAIL hold_operands: got %h/%h/%h expected %h/%h/%h", cap_code, cap_a, cap_b, op[6:0], a, b); end
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(1)) begin errors++; $display("FAIL busy_status: got %h expected %h", st, exp_status(1)); end
        pulse_res(res, f);
        m_result = res; m_flags = f; m_done = 1;
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL hold_done_status: got %h expected %h", st, exp_status(0)); end
        checks++; if (r !== m_result) begin errors++; $display("FAIL hold_result: got %h expected %h", r, m_result); end
    endtask

    task automatic test_timeout();
        logic [7:0] st; logic [DW-1:0] r, res; logic [3:0] f; logic ok; int p0;
        do_reset();
        op_ready = 1;
        res = $urandom; f = 4'($urandom_range(0, 15));
        p0 = pulses;
        spi_write(8'h02, $urandom, $urandom, FW);
        wait_pulse(p0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_first_issue: got none expected a pulse"); end
        m_accept();
        clk_n(4);
        pulse_res(res, f);
        m_result = res; m_flags = f; m_done = 1;
        p0 = pulses;
        spi_write(8'h03, $urandom, $urandom, FW);
        wait_pulse(p0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_second_issue: got none expected a pulse"); end
        m_accept();
        clk_n(TMO + 20);
        m_tmo = 1;
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL tmo_status: got %h expected %h", st, exp_status(0)); end
        checks++; if (r !== m_result) begin errors++; $display("FAIL tmo_result: got %h expected %h", r, m_result); end
        pulse_res(~res, ~f);
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL late_res_status: got %h expected %h", st, exp_status(0)); end
        checks++; if (r !== m_result) begin errors++; $display("FAIL late_res_result: got %h expected %h", r, m_result); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] st; logic [DW-1:0] r, res; logic ok; int p0;
        do_reset();
        op_ready = 1;
        res = $urandom;
        p0 = pulses;
        spi_write(8'h04, $urandom, $urandom, FW);
        wait_pulse(p0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_issue: got none expected a pulse"); end
        m_accept();
        clk_n(3);
        spi_write(8'h06, $urandom, $urandom, FW);
        m_rej = 1;
        clk_n(10);
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL b2b_no_second_issue: got %0d pulses expected 1", pulses - p0); end
        pulse_res(res, 4'h0);
        m_result = res; m_flags = 4'h0; m_done = 1;
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL b2b_status: got %h expected %h", st, exp_status(0)); end
        checks++; if (r !== m_result) begin errors++; $display("FAIL b2b_result: got %h expected %h", r, m_result); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] st; logic [DW-1:0] r; logic ok; int p0;
        do_reset();
        op_ready = 1;
        p0 = pulses;
        spi_write(8'h07, $urandom, $urandom, FW);
        wait_pulse(p0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstw_issue: got none expected a pulse"); end
        clk_n(3);
        rst = 1; clk_n(1); rst = 0;
        m_clear();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rstw_op_valid: got %b expected 0", op_valid); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstw_miso: got %b expected 0", miso); end
        pulse_res($urandom, 4'hF);
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL rstw_status: got %h expected %h", st, exp_status(0)); end
        checks++; if (r !== m_result) begin errors++; $display("FAIL rstw_result: got %h expected %h", r, m_result); end
        op_ready = 0;
        spi_write(8'h08, $urandom, $urandom, FW);
        clk_n(10);
        rst = 1; clk_n(1); rst = 0;
        m_clear();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rsti_op_valid: got %b expected 0", op_valid); end
        spi_write(8'h09, $urandom, $urandom, FW - 1);
        m_rej = 1;
        spi_read(st, r, 11);
        m_clear();
        checks++; if (miso_after_rst !== 1'b0) begin errors++; $display("FAIL rstr_miso: got %b expected 0", miso_after_rst); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rstr_op_valid: got %b expected 0", op_valid); end
        spi_read(st, r, -1);
        checks++; if (st !== exp_status(0)) begin errors++; $display("FAIL rstr_status: got %h expected %h", st, exp_status(0)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bad_frames();
        test_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
